riscv_hpc_roi: RTL

Hardware performance counter with region-of-interest (ROI) windowing, fed by the issue stage's retire port. It tracks every retired instruction and exposes the last retired PC and a free-running retire count. Between a configured start PC and end PC it accumulates the instruction count and the cycle count. Benches and software read it to measure a kernel (e.g. conv) without counting instructions by PC polling.

---
 rtl/riscv_hpc_roi.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/riscv_hpc_roi.sv
// Retire-driven performance counter with a PC-delimited region-of-interest window.
// Optional taken-branch counter enabled by defining HPC_ROI_BRANCH_CNT_EN.
module riscv_hpc_roi #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_x,
    input  logic             rst_cpu_i,
    input  logic             cfg_en_i,
    input  logic [31:0]      cfg_start_pc_i,
    input  logic [31:0]      cfg_end_pc_i,
    input  logic             retire_valid_i,
    input  logic [31:0]      retire_pc_i,
    input  logic             retire_br_taken_i,
    output logic [31:0]      req_pc_o,
    output logic [31:0]      HPC_req_retired_o,
    output logic [CNT_W-1:0] roi_inst_cnt_o,
    output logic [CNT_W-1:0] roi_cycle_cnt_o,
    output logic [CNT_W-1:0] roi_br_cnt_o,
    output logic [1:0]       roi_state_o,
    output logic             roi_done_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } roi_state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    roi_state_e       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_retired;
    logic [CNT_W-1:0] r_inst;
    logic [CNT_W-1:0] r_cyc;
    logic             r_done;

    logic             w_hit_start;
    logic             w_hit_end;
    logic [CNT_W-1:0] w_inst_inc;
    logic [CNT_W-1:0] w_cyc_inc;

    assign w_hit_start = retire_valid_i && (retire_pc_i == cfg_start_pc_i);
    assign w_hit_end   = retire_valid_i && (retire_pc_i == cfg_end_pc_i);

    // Saturating increments: ROI counters stick at all-ones instead of wrapping.
    assign w_inst_inc = (r_inst == CntMax) ? r_inst : r_inst + CntOne;
    assign w_cyc_inc  = (r_cyc == CntMax) ? r_cyc : r_cyc + CntOne;

`ifdef HPC_ROI_BRANCH_CNT_EN
    logic [CNT_W-1:0] r_br;
    logic [CNT_W-1:0] w_br_next;
    logic [CNT_W-1:0] w_br_first;

    assign w_br_next  = (retire_br_taken_i && (r_br != CntMax)) ? r_br + CntOne : r_br;
    assign w_br_first = retire_br_taken_i ? CntOne : '0;
    assign roi_br_cnt_o = r_br;
`else
    logic w_unused_br;

    assign w_unused_br  = retire_br_taken_i;
    assign roi_br_cnt_o = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_x) begin
        if (!rst_x) begin
            r_state   <= StIdle;
            r_pc      <= '0;
            r_retired <= '0;
            r_inst    <= '0;
            r_cyc     <= '0;
            r_done    <= 1'b0;
`ifdef HPC_ROI_BRANCH_CNT_EN
            r_br      <= '0;
`endif
        end else if (rst_cpu_i) begin
            r_state   <= StIdle;
            r_pc      <= '0;
            r_retired <= '0;
            r_inst    <= '0;
            r_cyc     <= '0;
            r_done    <= 1'b0;
`ifdef HPC_ROI_BRANCH_CNT_EN
            r_br      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            // Retire tracking is independent of the ROI window.
            if (retire_valid_i) begin
                r_pc      <= retire_pc_i;
                r_retired <= r_retired + 32'd1;
            end
            if (!cfg_en_i) begin
                r_state <= StIdle;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_state <= StArmed;
                        r_inst  <= '0;
                        r_cyc   <= '0;
`ifdef HPC_ROI_BRANCH_CNT_EN
                        r_br    <= '0;
`endif
                    end
                    StArmed: begin
                        if (w_hit_start) begin
                            r_inst <= CntOne;
                            r_cyc  <= CntOne;
`ifdef HPC_ROI_BRANCH_CNT_EN
                            r_br   <= w_br_first;
`endif
                            if (w_hit_end) begin
                                r_state <= StDone;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= StRun;
                            end
                        end
                    end
                    StRun: begin
                        r_cyc <= w_cyc_inc;
                        if (retire_valid_i) begin
                            r_inst <= w_inst_inc;
`ifdef HPC_ROI_BRANCH_CNT_EN
                            r_br   <= w_br_next;
`endif
                        end
                        if (w_hit_end) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end
                    end
                    StDone: begin
                        r_state <= StDone;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign req_pc_o          = r_pc;
    assign HPC_req_retired_o = r_retired;
    assign roi_inst_cnt_o    = r_inst;
    assign roi_cycle_cnt_o   = r_cyc;
    assign roi_state_o       = r_state;
    assign roi_done_o        = r_done;

endmodule
